xor_stream_cipher: RTL
======================

// Module: xor_stream_cipher
// PURPOSE
//   Parametrised successor to the fixed-key XOR cipher. It is a streaming XOR encrypt/decrypt engine with
//   valid/ready handshakes on both sides. The key (KEY_WORDS x DATA_W) is loaded word-serially at run time.
//   Two modes: static rotating key, or Galois-LFSR keystream seeded from the key.
//   The block sits between the pad-level input register and the output pins in the tile top level.
// PARAMETERS
//   DATA_W     8             data/key word width, bits
//   KEY_WORDS  4             key length in words; KW = KEY_WORDS*DATA_W is the LFSR state width
//   LFSR_TAPS  32'h80200003  Galois tap mask, KW bits wide (default is for KW=32)
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   key_load   in   1        pulse: abort current stream, start key load
//   key_valid  in   1        key_word qualifier while loading
//   key_word   in   DATA_W   key word; first word -> key[DATA_W-1:0]
//   mode       in   1        0 = static rotating key, 1 = LFSR keystream; sampled on the final key word
//   s_valid    in   1        input beat valid
//   s_data     in   DATA_W   plaintext/ciphertext in
//   s_ready    out  1        input beat accepted when s_valid & s_ready
//   m_valid    out  1        output beat valid
//   m_data     out  DATA_W   s_data XOR keystream word
//   m_ready    in   1        downstream accepts when m_valid & m_ready
//   key_ok     out  1        key loaded, RUN state
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; key, LFSR state, word index and mode register cleared.
//   FSM states: IDLE, LOAD, RUN.
//   - IDLE -> LOAD on key_load.
//   - LOAD: each key_valid writes key_word at the word index, then the index increments.
//     On word KEY_WORDS-1: latch mode, index=0, load the LFSR seed, go to RUN next cycle.
//   - RUN -> LOAD on key_load. That cycle clears m_valid, discards the pending beat and the partial key.
//   - key_load has priority over key_valid and s_valid in every state.
//   key_ok = (state==RUN).
//   s_ready = key_ok & (~m_valid | m_ready), a registered-output pipeline. s_ready is 0 in the cycle key_load is high.
//   Latency: a beat accepted in cycle N appears on m_data/m_valid in N+1.
//   Full throughput: 1 beat/cycle while m_ready=1.
//   m_data and m_valid hold stable while m_valid & ~m_ready.
//   Static mode: ks = key word[idx]. idx advances only on an accepted beat and wraps KEY_WORDS-1 -> 0.
//   LFSR mode: ks = lfsr[DATA_W-1:0] before advance.
//   - Each accepted beat advances one step: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
//   - Seed = key. An all-zero key seeds 1, so the LFSR never locks up.
//   The keystream does not advance on stalls, in IDLE/LOAD, or on non-accepted s_valid.
//   No carries: all arithmetic is bitwise XOR, DATA_W wide. idx is $clog2(KEY_WORDS) bits, or 1 bit if KEY_WORDS=1.
//   key_valid outside LOAD, and s_valid outside RUN, are ignored.
//   Reset mid-stream or mid-load returns to IDLE immediately; the output beat is lost.
//   Decryption equals encryption: same key, same mode and same beat order give the plaintext back.
// TESTING
//   1 Static: load 11,22,33,44 mode=0; send 00 x5 with m_ready=1 -> m_data 11,22,33,44,11; one-cycle latency.
//   2 LFSR zero key: load 00 x4 mode=1; send 00,00 -> m_data 01,03. Also check state 0x80200003 after beat 1.
//   3 Backpressure: scenario 1 with m_ready=0 for 3 cycles after the first beat.
//     -> m_data holds 11, s_ready=0, and the next beat still gets 22; no loss or duplication.
//   4 Round trip: encrypt A5,5A,FF,00 under key DEADBEEF in both modes; reload the same key; feed the ciphertext
//     -> output is A5,5A,FF,00.
//   5 Reload mid-stream: send 2 beats, assert key_load with m_valid=1.
//     -> m_valid=0 the next cycle, key_ok=0 until 4 new words load, and the stream restarts at key word 0.
//   6 Async reset: drop rst_n mid-load (after 2 words) and mid-stream, off the clock edge.
//     -> all outputs 0 immediately and state IDLE; s_data is ignored until a fresh key load.

Source files
------------

// File: rtl/xor_stream_cipher.sv
// -----------------------------------------------------------------------------
// xor_stream_cipher
//   Streaming XOR encrypt/decrypt engine. Encryption and decryption are the
//   same operation. The key is loaded one word at a time and is then used in
//   one of two ways: as a rotating static key, or as the seed of a Galois LFSR
//   keystream. Both the input and output sides use valid/ready handshakes,
//   and the output is a single registered pipeline stage.
//
// Parameters
//   DATA_W     data/key word width in bits
//   KEY_WORDS  key length in words; KW = KEY_WORDS*DATA_W is the LFSR width
//   LFSR_TAPS  Galois tap mask, KW bits wide
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   key_load   pulse: abort the current stream and start a key load
//   key_valid  qualifies key_word while loading
//   key_word   key word; the first word lands in key[DATA_W-1:0]
//   mode       0 = static rotating key, 1 = LFSR keystream (sampled on last word)
//   s_valid    input beat valid
//   s_data     plaintext/ciphertext in
//   s_ready    input beat accepted when s_valid & s_ready
//   m_valid    output beat valid
//   m_data     s_data XOR keystream word
//   m_ready    downstream accepts when m_valid & m_ready
//   key_ok     key loaded; stream running
// -----------------------------------------------------------------------------
module xor_stream_cipher #(
    parameter int unsigned                       DATA_W    = 8,
    parameter int unsigned                       KEY_WORDS = 4,
    parameter logic [KEY_WORDS*DATA_W-1:0]       LFSR_TAPS = 32'h80200003
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic              key_valid,
    input  logic [DATA_W-1:0] key_word,
    input  logic              mode,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              key_ok
);

    localparam int unsigned KW       = KEY_WORDS * DATA_W;
    localparam int unsigned IDX_W    = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t state_q;
    state_t state_d;

    // Key storage, load word index, static-key stream index, LFSR, mode.
    logic [KEY_WORDS-1:0][DATA_W-1:0] key_q;
    logic [IDX_W-1:0]                 widx_q;
    logic [IDX_W-1:0]                 sidx_q;
    logic [KW-1:0]                    lfsr_q;
    logic                             mode_q;

    // Control strobes from the FSM.
    logic load_wr;
    logic load_last;
    logic accept;

    // Datapath helpers.
    logic [KEY_WORDS-1:0][DATA_W-1:0] key_merged;
    logic [KW-1:0]                    seed;
    logic [KW-1:0]                    lfsr_step;
    logic [IDX_W-1:0]                 sidx_next;
    logic [IDX_W-1:0]                 widx_next;
    logic [DATA_W-1:0]                ks;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs. key_load wins over key_valid and s_valid in every
    // state, so s_ready is forced low in the cycle it is asserted.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        key_ok    = 1'b0;
        s_ready   = 1'b0;
        load_wr   = 1'b0;
        load_last = 1'b0;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (key_load) begin
                    state_d = ST_LOAD;
                end else if (key_valid) begin
                    load_wr = 1'b1;
                    if (widx_q == LAST_IDX) begin
                        load_last = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                key_ok = 1'b1;
                if (key_load) begin
                    state_d = ST_LOAD;
                end else begin
                    s_ready = ~m_valid | m_ready;
                    accept  = s_valid & s_ready;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    always_comb begin
        // The seed must include the word arriving this cycle, which is not
        // yet in key_q.
        key_merged         = key_q;
        key_merged[widx_q] = key_word;
        seed               = (key_merged == '0) ? KW'(1) : key_merged;

        lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

        sidx_next = (sidx_q == LAST_IDX) ? '0 : sidx_q + 1'b1;
        widx_next = (widx_q == LAST_IDX) ? '0 : widx_q + 1'b1;

        ks = mode_q ? lfsr_q[DATA_W-1:0] : key_q[sidx_q];
    end

    // -------------------------------------------------------------------------
    // Key, keystream and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            widx_q  <= '0;
            sidx_q  <= '0;
            lfsr_q  <= '0;
            mode_q  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (key_load) begin
            // Abort: drop the pending output beat and any partial key.
            key_q   <= '0;
            widx_q  <= '0;
            sidx_q  <= '0;
            m_valid <= 1'b0;
        end else begin
            if (load_wr) begin
                key_q[widx_q] <= key_word;
                widx_q        <= widx_next;
                if (load_last) begin
                    mode_q <= mode;
                    lfsr_q <= seed;
                    sidx_q <= '0;
                end
            end

            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= s_data ^ ks;
                if (mode_q) begin
                    lfsr_q <= lfsr_step;
                end else begin
                    sidx_q <= sidx_next;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
